// File: rtl/athena_loader_pkg.sv
// athena_loader_pkg
//   Shared types and constants for the Athena ioctl loader:
//   - region_e : ROM region identifiers (CPU1, CPU2, SND, SIDE, BACK, FRONT)
//   - state_e  : loader FSM states
//   - REG_BASE / REG_SIZE : byte layout of the index-0 ROM stream (MRA order)
//   - IDX_ROM / IDX_GAME / IDX_DIP : ioctl download indices
package athena_loader_pkg;

    localparam int NREG_PKG = 6;

    typedef enum logic [2:0] {
        REG_CPU1  = 3'd0,
        REG_CPU2  = 3'd1,
        REG_SND   = 3'd2,
        REG_SIDE  = 3'd3,
        REG_BACK  = 3'd4,
        REG_FRONT = 3'd5
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Regions are packed back to back in the index-0 stream.
    localparam logic [31:0] REG_BASE [NREG_PKG] = '{
        32'h0000_0000,  // CPU1
        32'h0001_0000,  // CPU2
        32'h0002_0000,  // SND
        32'h0003_0000,  // SIDE
        32'h0003_8000,  // BACK
        32'h0005_8000   // FRONT
    };

    localparam logic [31:0] REG_SIZE [NREG_PKG] = '{
        32'h0001_0000,  // CPU1  64 KiB
        32'h0001_0000,  // CPU2  64 KiB
        32'h0001_0000,  // SND   64 KiB
        32'h0000_8000,  // SIDE  32 KiB
        32'h0002_0000,  // BACK  128 KiB
        32'h0002_0000   // FRONT 128 KiB
    };

    localparam logic [7:0] IDX_ROM  = 8'd0;
    localparam logic [7:0] IDX_GAME = 8'd1;
    localparam logic [7:0] IDX_DIP  = 8'd254;

endpackage

// File: rtl/athena_region_dec.sv
// athena_region_dec
//   Combinational decode of an ioctl byte address against the package
//   region table. When several regions would match, the lowest-numbered
//   region wins.
//   Ports:
//     addr_i   : ioctl byte address
//     hit_o    : address falls inside one of the NREG regions
//     region_o : matching region number
//     laddr_o  : address relative to the region base
module athena_region_dec
    import athena_loader_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int RADDR_W = 18,
    parameter int NREG    = 6   // must not exceed NREG_PKG
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic               hit_o,
    output logic [2:0]         region_o,
    output logic [RADDR_W-1:0] laddr_o
);

    logic [31:0] a32;

    always_comb begin
        a32      = 32'(addr_i);
        hit_o    = 1'b0;
        region_o = 3'd0;
        laddr_o  = '0;
        // Walk from the top down so the lowest matching region is the last
        // assignment and therefore takes priority.
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((a32 >= REG_BASE[i]) && (a32 < (REG_BASE[i] + REG_SIZE[i]))) begin
                hit_o    = 1'b1;
                region_o = 3'(i);
                laddr_o  = RADDR_W'(a32 - REG_BASE[i]);
            end
        end
    end

endmodule

// File: rtl/athena_ioctl_loader.sv
// athena_ioctl_loader
//   Sequences the hps_io ioctl download stream into Athena storage:
//   index 0 bytes become ROM region writes (one outstanding, with ioctl_wait
//   backpressure), index 254 bytes fill the 64-bit DIP bank, and index 1
//   byte 0 sets the game id.
//   Optional feature macro: ATHENA_LOADER_CHECKSUM_EN adds rom_sum, a 16-bit
//   wrap-around sum of acknowledged ROM bytes.
//   Ports:
//     clk_sys, reset                 : clock, async active-high reset
//     ioctl_download/wr/index/addr/dout : hps_io download stream
//     ioctl_wait                     : backpressure while a ROM write is pending
//     rom_req/region/addr/data       : region write request, held until rom_ack
//     rom_ack                        : one-cycle write acknowledge
//     dsw                            : DIP bank (byte n = switch byte n)
//     game                           : game id
//     rom_loaded                     : index-0 download completed and drained
//     err_drop                       : sticky, a byte was lost
//     rom_sum (optional)             : checksum of acknowledged ROM bytes
module athena_ioctl_loader
    import athena_loader_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int RADDR_W = 18,
    parameter int NREG    = 6
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [7:0]         ioctl_index,
    input  logic [ADDR_W-1:0]  ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic               ioctl_wait,
    output logic               rom_req,
    output logic [2:0]         rom_region,
    output logic [RADDR_W-1:0] rom_addr,
    output logic [7:0]         rom_data,
    input  logic               rom_ack,
    output logic [63:0]        dsw,
    output logic [7:0]         game,
    output logic               rom_loaded,
    output logic               err_drop
`ifdef ATHENA_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]        rom_sum
`endif
);

    state_e               state_q;
    logic                 dl_q;
    logic                 req_q;
    logic                 wait_q;
    region_e              region_q;
    logic [RADDR_W-1:0]   raddr_q;
    logic [7:0]           data_q;
    logic [63:0]          dsw_q;
    logic [7:0]           game_q;
    logic                 loaded_q;
    logic                 err_q;
`ifdef ATHENA_LOADER_CHECKSUM_EN
    logic [15:0]          sum_q;
`endif

    logic                 dec_hit;
    logic [2:0]           dec_region;
    logic [RADDR_W-1:0]   dec_laddr;

    athena_region_dec #(
        .ADDR_W  (ADDR_W),
        .RADDR_W (RADDR_W),
        .NREG    (NREG)
    ) u_dec (
        .addr_i   (ioctl_addr),
        .hit_o    (dec_hit),
        .region_o (dec_region),
        .laddr_o  (dec_laddr)
    );

    logic idx_rom, dl_rise, dl_fall, rom_wr, dip_wr, game_wr;

    always_comb begin
        idx_rom = (ioctl_index == IDX_ROM);
        dl_rise = ioctl_download & ~dl_q;
        dl_fall = ~ioctl_download & dl_q;
        rom_wr  = ioctl_wr & idx_rom;
        dip_wr  = ioctl_wr & (ioctl_index == IDX_DIP) & (ioctl_addr[ADDR_W-1:3] == '0);
        game_wr = ioctl_wr & (ioctl_index == IDX_GAME) & (ioctl_addr == '0);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dl_q     <= 1'b0;
            req_q    <= 1'b0;
            wait_q   <= 1'b0;
            region_q <= REG_CPU1;
            raddr_q  <= '0;
            data_q   <= 8'h00;
            dsw_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
            game_q   <= 8'h00;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef ATHENA_LOADER_CHECKSUM_EN
            sum_q    <= 16'h0000;
`endif
        end else begin
            dl_q <= ioctl_download;

            // Start of a ROM download: forget the previous download's status.
            if (dl_rise && idx_rom) begin
                loaded_q <= 1'b0;
                err_q    <= 1'b0;
`ifdef ATHENA_LOADER_CHECKSUM_EN
                sum_q    <= 16'h0000;
`endif
            end

            if (dip_wr) begin
                dsw_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end
            if (game_wr) begin
                game_q <= ioctl_dout;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rom_wr) begin
                        if (dec_hit) begin
                            region_q <= region_e'(dec_region);
                            raddr_q  <= dec_laddr;
                            data_q   <= ioctl_dout;
                            req_q    <= 1'b1;
                            wait_q   <= 1'b1;
                            state_q  <= ST_ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (dl_fall && idx_rom && !(rom_wr && dec_hit)) begin
                        loaded_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // The single buffer is busy: any new ROM byte is lost,
                    // even one arriving alongside the ack.
                    if (rom_wr) begin
                        err_q <= 1'b1;
                    end
                    if (rom_ack) begin
                        req_q   <= 1'b0;
                        wait_q  <= 1'b0;
                        state_q <= ST_IDLE;
`ifdef ATHENA_LOADER_CHECKSUM_EN
                        if (!loaded_q) sum_q <= sum_q + {8'h00, data_q};
`endif
                        if (dl_fall && idx_rom) begin
                            loaded_q <= 1'b1;
                        end
                    end else if (dl_fall && idx_rom) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (rom_wr) begin
                        err_q <= 1'b1;
                    end
                    if (rom_ack) begin
                        req_q    <= 1'b0;
                        wait_q   <= 1'b0;
                        loaded_q <= 1'b1;
                        state_q  <= ST_IDLE;
`ifdef ATHENA_LOADER_CHECKSUM_EN
                        if (!loaded_q) sum_q <= sum_q + {8'h00, data_q};
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ioctl_wait = wait_q;
    assign rom_req    = req_q;
    assign rom_region = region_q;
    assign rom_addr   = raddr_q;
    assign rom_data   = data_q;
    assign dsw        = dsw_q;
    assign game       = game_q;
    assign rom_loaded = loaded_q;
    assign err_drop   = err_q;
`ifdef ATHENA_LOADER_CHECKSUM_EN
    assign rom_sum    = sum_q;
`endif

endmodule

// File: tb/tb_athena_ioctl_loader.sv
// tb_athena_ioctl_loader
//   Directed bench for athena_ioctl_loader. Inputs change 1 time unit after
//   the rising clock edge and outputs are sampled at that same point.
module tb_athena_ioctl_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        rom_req;
    logic [2:0]  rom_region;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ack;
    logic [63:0] dsw;
    logic [7:0]  game;
    logic        rom_loaded;
    logic        err_drop;
`ifdef ATHENA_LOADER_CHECKSUM_EN
    logic [15:0] rom_sum;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    athena_ioctl_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_req        (rom_req),
        .rom_region     (rom_region),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_ack        (rom_ack),
        .dsw            (dsw),
        .game           (game),
        .rom_loaded     (rom_loaded),
        .err_drop       (err_drop)
`ifdef ATHENA_LOADER_CHECKSUM_EN
        ,
        .rom_sum        (rom_sum)
`endif
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle ioctl byte strobe.
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack();
        rom_ack = 1'b1;
        step();
        rom_ack = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        rom_ack        = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_dsw",    dsw,        64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_game",   {56'd0, game}, 64'd0);
        chk("rst_req",    {63'd0, rom_req}, 64'd0);
        chk("rst_wait",   {63'd0, ioctl_wait}, 64'd0);
        chk("rst_loaded", {63'd0, rom_loaded}, 64'd0);
        chk("rst_err",    {63'd0, err_drop}, 64'd0);
        reset = 1'b0;
        step();

        // DIP bank, index 254
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        wr_byte(25'h0, 8'h3C);
        chk("dip_b0", {56'd0, dsw[7:0]}, 64'h3C);
        wr_byte(25'h1, 8'hA5);
        wr_byte(25'h8, 8'h00);
        chk("dip_bank", dsw, 64'hFFFF_FFFF_FFFF_A53C);
        chk("dip_nowait", {63'd0, ioctl_wait}, 64'd0);
        ioctl_download = 1'b0;
        step();

        // Game id, index 1
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        wr_byte(25'h0, 8'h02);
        chk("game_set", {56'd0, game}, 64'h02);
        wr_byte(25'h1, 8'h77);
        chk("game_ign", {56'd0, game}, 64'h02);
        ioctl_download = 1'b0;
        step();

        // ROM byte into SND (region 2), ack 4 cycles after the strobe
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        step();
        wr_byte(25'h20010, 8'h5A);
        chk("iss_req",    {63'd0, rom_req}, 64'd1);
        chk("iss_wait",   {63'd0, ioctl_wait}, 64'd1);
        chk("iss_region", {61'd0, rom_region}, 64'd2);
        chk("iss_addr",   {46'd0, rom_addr}, 64'h10);
        chk("iss_data",   {56'd0, rom_data}, 64'h5A);
        step();
        // Overrun: dropped, buffer untouched
        wr_byte(25'h20011, 8'h77);
        chk("ovr_err",  {63'd0, err_drop}, 64'd1);
        chk("ovr_req",  {63'd0, rom_req}, 64'd1);
        chk("ovr_addr", {46'd0, rom_addr}, 64'h10);
        chk("ovr_data", {56'd0, rom_data}, 64'h5A);
        ack();
        chk("ack_req",  {63'd0, rom_req}, 64'd0);
        chk("ack_wait", {63'd0, ioctl_wait}, 64'd0);
        // Stray ack in IDLE is ignored
        ack();
        chk("stray_req", {63'd0, rom_req}, 64'd0);
        // Lowest region, first byte
        wr_byte(25'h0, 8'h11);
        chk("cpu1_region", {61'd0, rom_region}, 64'd0);
        chk("cpu1_addr",   {46'd0, rom_addr}, 64'h0);
        chk("cpu1_data",   {56'd0, rom_data}, 64'h11);
        step();
        chk("cpu1_hold",   {63'd0, rom_req}, 64'd1);
        ack();
        // Last byte of SIDE (just below BACK base)
        wr_byte(25'h37FFF, 8'h22);
        chk("side_region", {61'd0, rom_region}, 64'd3);
        chk("side_addr",   {46'd0, rom_addr}, 64'h7FFF);
        ack();
        chk("pre_loaded", {63'd0, rom_loaded}, 64'd0);
        ioctl_download = 1'b0;
        step();
        chk("idle_loaded", {63'd0, rom_loaded}, 64'd1);

        // Out-of-range address
        ioctl_download = 1'b1;
        step();
        chk("rise_err",    {63'd0, err_drop}, 64'd0);
        chk("rise_loaded", {63'd0, rom_loaded}, 64'd0);
        wr_byte(25'h78000, 8'h99);
        chk("oor_err",  {63'd0, err_drop}, 64'd1);
        chk("oor_wait", {63'd0, ioctl_wait}, 64'd0);
        chk("oor_req",  {63'd0, rom_req}, 64'd0);
        ioctl_download = 1'b0;
        step();

        // Download ends with a request still pending
        ioctl_download = 1'b1;
        step();
        wr_byte(25'h58005, 8'hFF);
        chk("front_region", {61'd0, rom_region}, 64'd5);
        chk("front_addr",   {46'd0, rom_addr}, 64'h5);
        ack();
        wr_byte(25'h58006, 8'h02);
        ioctl_download = 1'b0;
        step();
        chk("flush_loaded0", {63'd0, rom_loaded}, 64'd0);
        chk("flush_req",     {63'd0, rom_req}, 64'd1);
        step();
        chk("flush_loaded1", {63'd0, rom_loaded}, 64'd0);
        ack();
        chk("flush_done", {63'd0, rom_loaded}, 64'd1);
        chk("flush_rel",  {63'd0, rom_req}, 64'd0);
        chk("flush_wait", {63'd0, ioctl_wait}, 64'd0);
`ifdef ATHENA_LOADER_CHECKSUM_EN
        chk("sum", {48'd0, rom_sum}, 64'h0101);
`endif

        // Reset in the middle of a request
        ioctl_download = 1'b1;
        step();
        wr_byte(25'h100, 8'h33);
        chk("mid_req", {63'd0, rom_req}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req",  {63'd0, rom_req}, 64'd0);
        chk("mid_rst_dsw",  dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mid_rst_game", {56'd0, game}, 64'd0);
`ifdef ATHENA_LOADER_CHECKSUM_EN
        chk("mid_rst_sum",  {48'd0, rom_sum}, 64'd0);
`endif
        ioctl_download = 1'b0;
        step();
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/athena_ioctl_loader.md
Name: athena_ioctl_loader

Overview:
- Sequences the HPS ioctl download stream into the Athena core's storage resources.
- Decodes index 0 bytes into ROM region writes, index 254 bytes into the 8-byte DIP bank, and the index 1 byte 0 into the game-id register.
- Applies ioctl_wait backpressure while a ROM write is outstanding to the slower region memory port.
- Sits between hps_io and AthenaCore, replacing ad-hoc DIP/game capture logic.

Parameters:
- ADDR_W, 25, ioctl address width.
- RADDR_W, 18, region-local address width.
- NREG, 6, number of ROM regions decoded (CPU1, CPU2, SND, SIDE, BACK, FRONT).

Ports:
- clk_sys  in  1  system clock (53.6 MHz)
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  download active
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_index  in  8  download index
- ioctl_addr  in  ADDR_W  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  backpressure to hps_io
- rom_req  out  1  region write request, held until ack
- rom_region  out  3  target region number
- rom_addr  out  RADDR_W  region-local address
- rom_data  out  8  write data
- rom_ack  in  1  one-cycle write acknowledge
- dsw  out  64  DIP bank; byte n = switch byte n
- game  out  8  game id
- rom_loaded  out  1  set when an index-0 download has completed and drained
- err_drop  out  1  sticky: byte lost (overrun or out-of-range)

Behaviour:
- Reset values: all outputs 0, except dsw = 64'hFFFF_FFFF_FFFF_FFFF (switches inactive). FSM goes to IDLE.
- FSM states: IDLE, ISSUE, FLUSH.
- IDLE, ioctl_wr with index 0:
  - Decode ioctl_addr against the package region table (base, size).
  - In range: latch region, addr - base, and data; go to ISSUE.
  - rom_req, ioctl_wait, rom_region, rom_addr and rom_data are valid on the cycle after ioctl_wr (latency 1).
- ISSUE:
  - Hold rom_req and all rom_* fields stable.
  - On rom_ack: drop rom_req and ioctl_wait on the next cycle, return to IDLE. Minimum per-byte occupancy is 2 cycles.
- Overrun: ioctl_wr while in ISSUE means the byte is dropped and err_drop is set. The buffer is not overwritten.
- Out-of-range index-0 address: byte dropped, err_drop set, no wait asserted, state unchanged.
- Index 254:
  - If ioctl_addr[24:3] == 0, write dsw[8*addr[2:0] +: 8] in the same cycle; no wait.
  - Otherwise ignored (not an error).
- Index 1, ioctl_addr == 0, ioctl_wr: game <= ioctl_dout. Other index-1 bytes are ignored.
- Download boundaries:
  - Rising edge of ioctl_download with index 0 clears rom_loaded and err_drop.
  - Falling edge with index 0 goes to FLUSH if in ISSUE, else sets rom_loaded next cycle.
  - FLUSH: on rom_ack, set rom_loaded and go to IDLE.
- Simultaneous events: ack and a new ioctl_wr in the same cycle in ISSUE count as overrun. hps_io must honour wait; the block does not pipeline.
- rom_ack while not in ISSUE: ignored.
- Reset mid-ISSUE: request abandoned, rom_req low immediately (asynchronous), DIP/game revert to reset values.

Optional Feature:
- Macro ATHENA_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output rom_sum[15:0]: 16-bit wrap-around sum of every byte acknowledged via rom_ack during index 0.
  - Cleared on the download rising edge and on reset; frozen once rom_loaded is set.
- Undefined: port absent, no adder logic.

Decomposition:
- Package athena_loader_pkg:
  - typedef enum for region id (REG_CPU1..REG_FRONT).
  - typedef enum for FSM state.
  - localparam arrays REG_BASE[NREG] and REG_SIZE[NREG] matching the MRA layout.
  - localparams IDX_ROM=0, IDX_GAME=1, IDX_DIP=254.
- One sub-module athena_region_dec: combinational address to {hit, region, local addr}, priority lowest region first.

Test Plan:
- Reset → dsw = all-ones, game = 0, rom_req = 0, ioctl_wait = 0, rom_loaded = 0.
- Index 254, bytes 0x3C at addr 0 and 0xA5 at addr 1 → dsw[7:0] = 0x3C, dsw[15:8] = 0xA5, rest 0xFF. Addr 8 → no change.
- Index 0, byte 0x5A at REG_BASE[2]+0x10, ack delayed 4 cycles:
  - Cycle+1: rom_req = 1, rom_region = 2, rom_addr = 0x10, rom_data = 0x5A, ioctl_wait = 1.
  - Both drop the cycle after ack.
- Second ioctl_wr during ISSUE → err_drop = 1, first request unchanged, exactly one ack consumed.
- Download falls while ISSUE pending → rom_loaded stays 0 until ack, then 1. Index-1 addr 0 byte 0x02 → game = 0x02.
- With ATHENA_LOADER_CHECKSUM_EN: bytes 0xFF, 0x02 acknowledged → rom_sum = 0x0101. Reset mid-ISSUE → rom_req = 0 same cycle, rom_sum = 0.
